// File: rtl/colors_to_bytes_pkg.sv
// Shared widths, phase encoding and a constant-width helper for the
// color-to-byte unpacker and its byte FIFO.
package colors_to_bytes_pkg;

  localparam int BYTE_LEN   = 8;
  localparam int COLOR_LEN  = 12;
  localparam int NIBBLE_LEN = COLOR_LEN - BYTE_LEN;

  // PH_SECOND means a nibble from the previous color is waiting to be joined
  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  // Ceiling log2, usable in parameter and localparam expressions
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/colors_to_bytes_byte_fifo.sv
// Small synchronous FIFO that takes one or two entries per cycle and
// gives back one. When empty, head shows the most recently popped entry,
// so a consumer that ignores the strobe still sees a stable value.
module byte_fifo
  import colors_to_bytes_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   push2,
  input  logic [WIDTH-1:0]       wr_data0,
  input  logic [WIDTH-1:0]       wr_data1,
  input  logic                   pop,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  free,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] last_pop;
  logic [AW:0]      push_cnt;
  logic             do_pop;

  // push2 only takes effect together with push: it adds a second entry
  always_comb begin
    push_cnt = '0;
    if (push) begin
      push_cnt = push2 ? (AW+1)'(2) : (AW+1)'(1);
    end
  end

  assign do_pop = pop && (count != '0);
  assign empty  = (count == '0);
  assign free   = (AW+1)'(DEPTH) - count;
  assign head   = empty ? last_pop : mem[rd_ptr];

  // Pointers, occupancy and the last popped entry; pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_pop <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(push_cnt);
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        last_pop <= mem[rd_ptr];
      end
      count <= count + push_cnt - (AW+1)'(do_pop);
    end
  end

  // Storage writes; contents are only ever read while counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data0;
      if (push2) begin
        mem[wr_ptr + AW'(1)] <= wr_data1;
      end
    end
  end

endmodule

// File: rtl/colors_to_bytes.sv
// Unpacks 12-bit colors into an MSB-first 8-bit bytestream: two colors
// become three bytes, and an odd trailing color is padded with zeros.
module colors_to_bytes
  import colors_to_bytes_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inclk,
  input  logic [COLOR_LEN-1:0] in,
  input  logic                 in_done,
  input  logic                 downstream_rdy,
  output logic                 rdy,
  output logic                 outclk,
  output logic [BYTE_LEN-1:0]  out,
  output logic                 done,
  output logic                 overflow
);

  localparam int AW = clog2(FIFO_DEPTH);

  phase_t                phase, phase_next;
  logic [NIBBLE_LEN-1:0] nibble, nibble_next;
  logic                  overflow_next;
  logic                  accept;
  logic                  push, push2;
  logic [BYTE_LEN:0]     wr_data0, wr_data1;
  logic                  empty;
  logic [AW:0]           free;
  logic [BYTE_LEN:0]     head;

  byte_fifo #(
    .WIDTH (BYTE_LEN + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push2    (push2),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .pop      (outclk),
    .empty    (empty),
    .free     (free),
    .head     (head)
  );

  // Room for two bytes means any accepted color can be stored whole
  assign rdy    = (free >= (AW+1)'(2)) && !rst;
  assign accept = inclk && rdy;

  assign outclk = !empty && downstream_rdy;
  assign out    = head[BYTE_LEN:1];
  assign done   = outclk && head[0];

  // Phase register, held nibble and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_FIRST;
      nibble   <= '0;
      overflow <= 1'b0;
    end else begin
      phase    <= phase_next;
      nibble   <= nibble_next;
      overflow <= overflow_next;
    end
  end

  // Split or join colors into bytes; entries are {byte, last}
  always_comb begin
    phase_next    = phase;
    nibble_next   = nibble;
    overflow_next = overflow || (inclk && !rdy);
    push          = 1'b0;
    push2         = 1'b0;
    wr_data0      = '0;
    wr_data1      = '0;
    if (accept) begin
      case (phase)
        PH_FIRST: begin
          push        = 1'b1;
          wr_data0    = {in[COLOR_LEN-1 -: BYTE_LEN], 1'b0};
          nibble_next = in[NIBBLE_LEN-1:0];
          if (in_done) begin
            push2    = 1'b1;
            wr_data1 = {in[NIBBLE_LEN-1:0], {(BYTE_LEN-NIBBLE_LEN){1'b0}}, 1'b1};
          end else begin
            phase_next = PH_SECOND;
          end
        end
        PH_SECOND: begin
          push       = 1'b1;
          push2      = 1'b1;
          wr_data0   = {nibble, in[COLOR_LEN-1 -: (BYTE_LEN-NIBBLE_LEN)], 1'b0};
          wr_data1   = {in[BYTE_LEN-1:0], in_done};
          phase_next = PH_FIRST;
        end
        default: phase_next = PH_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_colors_to_bytes.sv
// Self-checking bench for colors_to_bytes: directed streams plus a random
// phase, compared against a bit-accumulator model of the unpacking.
module tb_colors_to_bytes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inclk = 1'b0;
  logic [11:0] in_c = '0;
  logic        in_done = 1'b0;
  logic        downstream_rdy = 1'b0;
  logic        rdy, outclk, done, overflow;
  logic [7:0]  out;

  int checks = 0;
  int errors = 0;

  // Model state: pending bits of the stream, bytes in flight, sticky drop
  logic [8:0]  mq[$];
  logic [31:0] mbits;
  int          mnb;
  logic [7:0]  mlast;
  logic        movf;
  logic [7:0]  got[$];
  logic [7:0]  exp_seq[9];

  colors_to_bytes #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .inclk          (inclk),
    .in             (in_c),
    .in_done        (in_done),
    .downstream_rdy (downstream_rdy),
    .rdy            (rdy),
    .outclk         (outclk),
    .out            (out),
    .done           (done),
    .overflow       (overflow)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mbits = '0;
    mnb   = 0;
    mlast = '0;
    movf  = 1'b0;
  endtask

  // Append 12 bits to the stream; a finished stream is zero-padded to a byte
  task automatic modelAccept(input logic [11:0] color, input logic last);
    logic [7:0] b;
    mbits = (mbits << 12) | {20'd0, color};
    mnb   = mnb + 12;
    if (last && (mnb % 8) != 0) begin
      mbits = mbits << (8 - (mnb % 8));
      mnb   = mnb + (8 - (mnb % 8));
    end
    while (mnb >= 8) begin
      b   = 8'((mbits >> (mnb - 8)) & 32'hFF);
      mnb = mnb - 8;
      mq.push_back({b, last && (mnb == 0)});
    end
    mbits = mbits & ((32'd1 << mnb) - 32'd1);
  endtask

  // One cycle: drive at the falling edge, check, then advance the model
  task automatic applyStimulus(input logic ic, input logic [11:0] c, input logic d, input logic r);
    logic       exp_rdy, exp_outclk, exp_done;
    logic [7:0] exp_out;
    @(negedge clk);
    inclk = ic;
    in_c = c;
    in_done = d;
    downstream_rdy = r;
    #1;
    exp_rdy    = (4 - mq.size()) >= 2;
    exp_outclk = (mq.size() != 0) && r;
    exp_out    = mlast;
    exp_done   = 1'b0;
    if (mq.size() != 0) begin
      exp_out  = mq[0][8:1];
      exp_done = exp_outclk && mq[0][0];
    end
    checkOutput("rdy", rdy, exp_rdy);
    checkOutput("outclk", outclk, exp_outclk);
    checkOutput("out", out, exp_out);
    checkOutput("done", done, exp_done);
    checkOutput("overflow", overflow, movf);
    if (outclk) got.push_back(out);
    if (exp_outclk) begin
      mlast = mq[0][8:1];
      void'(mq.pop_front());
    end
    if (ic) begin
      if (exp_rdy) modelAccept(c, d);
      else movf = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
  endtask

  task automatic checkSeq(input string tag, input int n);
    checkOutput({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) checkOutput($sformatf("%s_byte%0d", tag, i), got[i], exp_seq[i]);
    end
    got.delete();
  endtask

  // Asynchronous reset in the middle of a cycle, checked while still held
  task automatic pulseReset();
    @(negedge clk);
    inclk = 1'b0;
    in_done = 1'b0;
    downstream_rdy = 1'b1;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_outclk", outclk, 1'b0);
    checkOutput("rst_out", out, 8'h00);
    checkOutput("rst_rdy_held", rdy, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    got.delete();
  endtask

  initial begin
    modelReset();
    #12;
    checkOutput("por_outclk", outclk, 1'b0);
    checkOutput("por_out", out, 8'h00);
    checkOutput("por_overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Even-length stream, one color every four cycles
    applyStimulus(1'b1, 12'hABC, 1'b0, 1'b1);
    idle(3);
    applyStimulus(1'b1, 12'hDEF, 1'b1, 1'b1);
    idle(5);
    exp_seq = '{8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    checkSeq("even", 3);

    // Odd-length stream followed by a fresh pair
    applyStimulus(1'b1, 12'h123, 1'b1, 1'b1);
    idle(4);
    exp_seq = '{8'h12, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    checkSeq("odd", 2);
    applyStimulus(1'b1, 12'h456, 1'b0, 1'b1);
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
    applyStimulus(1'b1, 12'h789, 1'b1, 1'b1);
    idle(5);
    exp_seq = '{8'h45, 8'h67, 8'h89, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    checkSeq("pair", 3);

    // Backpressure, then a dropped color while full
    applyStimulus(1'b1, 12'hABC, 1'b0, 1'b0);
    applyStimulus(1'b1, 12'hDEF, 1'b1, 1'b0);
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0);
    applyStimulus(1'b1, 12'hFFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0);
    checkOutput("ovf_set", overflow, 1'b1);
    idle(5);
    exp_seq = '{8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    checkSeq("bp", 3);
    idle(3);
    checkOutput("ovf_sticky", overflow, 1'b1);
    pulseReset();
    idle(1);

    // Back-to-back colors with simultaneous push and pop
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < 8 && (4 - mq.size()) < 2; w++) idle(1);
      applyStimulus(1'b1, 12'(k * 12'h111), k == 5, 1'b1);
    end
    idle(8);
    exp_seq = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h23, 8'h33, 8'h44, 8'h45, 8'h55};
    checkSeq("b2b", 9);
    checkOutput("b2b_overflow", overflow, 1'b0);

    // Reset with a nibble pending and a byte unread
    applyStimulus(1'b1, 12'hABC, 1'b0, 1'b0);
    pulseReset();
    applyStimulus(1'b1, 12'h123, 1'b0, 1'b1);
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
    applyStimulus(1'b1, 12'h456, 1'b1, 1'b1);
    idle(5);
    exp_seq = '{8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    checkSeq("post_rst", 3);

    // Random traffic, stalls and drops
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, 12'($urandom), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) != 0);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
